// File: rtl/uart_pkg.sv
// Shared types and widths for the UART link controller.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      RX_IDLE,
      RX_ACK
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_BUSY
   } tx_state_t;

   typedef enum logic {
      GNT_CPU,
      GNT_ECHO
   } grant_t;

endpackage

// File: rtl/uart_link_ctrl_if.sv
// Receiver, transmitter, CPU and status signals of the UART link controller.
interface uart_link_ctrl_if #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
);
   import uart_pkg::*;

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic                rx_receive;
   logic [BYTE_W-1:0]   rx_data;
   logic                rx_done;
   logic                cpu_rd_valid;
   logic [BYTE_W-1:0]   cpu_rd_data;
   logic                cpu_rd_ready;
   logic                cpu_tx_valid;
   logic [BYTE_W-1:0]   cpu_tx_data;
   logic                cpu_tx_ready;
   logic                echo_en;
   logic                tx_start;
   logic [BYTE_W-1:0]   tx_data;
   logic                tx_busy;
   logic                clr_status;
   logic [LVL_W-1:0]    rx_level;
   logic                overrun;
   logic [CNT_W-1:0]    overrun_cnt;
   logic                echo_drop;

   modport master (
      output rx_receive, rx_data, cpu_rd_ready, cpu_tx_valid, cpu_tx_data,
             echo_en, tx_busy, clr_status,
      input  rx_done, cpu_rd_valid, cpu_rd_data, cpu_tx_ready, tx_start,
             tx_data, rx_level, overrun, overrun_cnt, echo_drop
   );

   modport slave (
      input  rx_receive, rx_data, cpu_rd_ready, cpu_tx_valid, cpu_tx_data,
             echo_en, tx_busy, clr_status,
      output rx_done, cpu_rd_valid, cpu_rd_data, cpu_tx_ready, tx_start,
             tx_data, rx_level, overrun, overrun_cnt, echo_drop
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with occupancy output; DEPTH must be a power of two >= 2.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                              clk_in,
   input  logic                              nreset,
   input  logic                              push,
   input  logic [BYTE_W-1:0]                 push_data,
   input  logic                              pop,
   output logic [BYTE_W-1:0]                 head_data,
   output logic [$clog2(DEPTH):0]            level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok_c;
   logic              pop_ok_c;

   assign push_ok_c = push && (level < LVL_W'(DEPTH));
   assign pop_ok_c  = pop && (level != '0);

   // Head is forced to zero while empty so the read port idles at 0.
   assign head_data = (level != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk_in) begin
      if (push_ok_c) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!nreset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok_c, pop_ok_c})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: RX frame acknowledge + FIFO, echo buffer and
// round-robin sharing of the transmitter between CPU and echo.
module uart_link_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk_in,
   input  logic             nreset,
   uart_link_ctrl_if.slave  bus
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   rx_state_t          rx_state;
   tx_state_t          tx_state;
   grant_t             last_grant;

   logic               rx_done_q;
   logic               tx_start_q;
   logic               cpu_tx_ready_q;
   logic [BYTE_W-1:0]  tx_data_q;
   logic               overrun_q;
   logic [CNT_W-1:0]   overrun_cnt_q;
   logic               echo_drop_q;
   logic               echo_valid;
   logic [BYTE_W-1:0]  echo_byte;

   logic [LVL_W-1:0]   fifo_level;
   logic [BYTE_W-1:0]  fifo_head;

   logic               frame_c;
   logic               full_c;
   logic               push_c;
   logic               ovf_c;
   logic               pop_c;
   logic               echo_req_c;
   logic               grant_c;
   logic               gnt_cpu_c;

   // Full test uses the registered level only, so a same-cycle pop never rescues a push.
   assign frame_c    = (rx_state == RX_IDLE) && bus.rx_receive;
   assign full_c     = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign push_c     = frame_c && !full_c;
   assign ovf_c      = frame_c && full_c;
   assign pop_c      = (fifo_level != '0) && bus.cpu_rd_ready;
   assign echo_req_c = frame_c && bus.echo_en;

   // Round-robin: under contention the requester not granted last time wins.
   assign grant_c   = (tx_state == TX_IDLE) && !bus.tx_busy &&
                      (bus.cpu_tx_valid || echo_valid);
   assign gnt_cpu_c = bus.cpu_tx_valid && (!echo_valid || (last_grant == GNT_ECHO));

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk_in    (clk_in),
      .nreset    (nreset),
      .push      (push_c),
      .push_data (bus.rx_data),
      .pop       (pop_c),
      .head_data (fifo_head),
      .level     (fifo_level)
   );

   // Receiver handshake: one acknowledge per frame, held until the flag drops.
   always_ff @(posedge clk_in) begin
      if (!nreset) begin
         rx_state  <= RX_IDLE;
         rx_done_q <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (bus.rx_receive) begin
                  rx_done_q <= 1'b1;
                  rx_state  <= RX_ACK;
               end
            end
            RX_ACK: begin
               if (!bus.rx_receive) begin
                  rx_done_q <= 1'b0;
                  rx_state  <= RX_IDLE;
               end
            end
         endcase
      end
   end

   // Overrun status; a new overrun wins over a coincident clear.
   always_ff @(posedge clk_in) begin
      if (!nreset) begin
         overrun_q     <= 1'b0;
         overrun_cnt_q <= '0;
      end else begin
         if (bus.clr_status) begin
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
         end
         if (ovf_c) begin
            overrun_q <= 1'b1;
            if (bus.clr_status) begin
               overrun_cnt_q <= CNT_W'(1);
            end else if (overrun_cnt_q != '1) begin
               overrun_cnt_q <= overrun_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Single-entry echo buffer; a byte arriving while it is occupied is dropped.
   always_ff @(posedge clk_in) begin
      if (!nreset) begin
         echo_valid  <= 1'b0;
         echo_byte   <= '0;
         echo_drop_q <= 1'b0;
      end else begin
         if (bus.clr_status) begin
            echo_drop_q <= 1'b0;
         end
         if (grant_c && !gnt_cpu_c) begin
            echo_valid <= 1'b0;
         end
         if (echo_req_c) begin
            if (echo_valid) begin
               echo_drop_q <= 1'b1;
            end else begin
               echo_valid <= 1'b1;
               echo_byte  <= bus.rx_data;
            end
         end
      end
   end

   // Transmit sequencing: grant, hold start until busy, wait for busy to clear.
   always_ff @(posedge clk_in) begin
      if (!nreset) begin
         tx_state       <= TX_IDLE;
         tx_start_q     <= 1'b0;
         tx_data_q      <= '0;
         cpu_tx_ready_q <= 1'b0;
         last_grant     <= GNT_ECHO;
      end else begin
         cpu_tx_ready_q <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (grant_c) begin
                  tx_start_q     <= 1'b1;
                  tx_data_q      <= gnt_cpu_c ? bus.cpu_tx_data : echo_byte;
                  last_grant     <= gnt_cpu_c ? GNT_CPU : GNT_ECHO;
                  cpu_tx_ready_q <= gnt_cpu_c;
                  tx_state       <= TX_START;
               end
            end
            TX_START: begin
               if (bus.tx_busy) begin
                  tx_start_q <= 1'b0;
                  tx_state   <= TX_BUSY;
               end
            end
            TX_BUSY: begin
               if (!bus.tx_busy) begin
                  tx_state <= TX_IDLE;
               end
            end
            default: begin
               tx_start_q <= 1'b0;
               tx_state   <= TX_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_done      = rx_done_q;
   assign bus.cpu_rd_valid = (fifo_level != '0);
   assign bus.cpu_rd_data  = fifo_head;
   assign bus.cpu_tx_ready = cpu_tx_ready_q;
   assign bus.tx_start     = tx_start_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.rx_level     = fifo_level;
   assign bus.overrun      = overrun_q;
   assign bus.overrun_cnt  = overrun_cnt_q;
   assign bus.echo_drop    = echo_drop_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl with a simple transmitter busy model.
module tb_uart_link_ctrl;
   import uart_pkg::*;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned CNT_W      = 8;

   logic clk_in = 1'b0;
   logic nreset = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   int         busy_cnt   = 0;
   logic       busy_stuck = 1'b0;
   logic       model_en   = 1'b1;
   logic [7:0] tx_log [$];

   always #5 clk_in = ~clk_in;

   uart_link_ctrl_if #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) bus ();

   uart_link_ctrl #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_in (clk_in),
      .nreset (nreset),
      .bus    (bus)
   );

   // Transmitter model: busy for 10 cycles after it sees tx_start.
   assign bus.tx_busy = busy_stuck || (busy_cnt != 0);

   always @(posedge clk_in) begin
      if (!nreset) begin
         busy_cnt <= 0;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end else if (model_en && bus.tx_start && !busy_stuck) begin
         busy_cnt <= 10;
         tx_log.push_back(bus.tx_data);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      nreset           = 1'b0;
      bus.rx_receive   = 1'b0;
      bus.rx_data      = 8'h00;
      bus.cpu_rd_ready = 1'b0;
      bus.cpu_tx_valid = 1'b0;
      bus.cpu_tx_data  = 8'h00;
      bus.echo_en      = 1'b0;
      bus.clr_status   = 1'b0;
      busy_stuck       = 1'b0;
      model_en         = 1'b1;
      tick();
      tick();
      nreset = 1'b1;
      tx_log.delete();
   endtask

   task automatic send_frame(input logic [7:0] d);
      int n;
      bus.rx_data    = d;
      bus.rx_receive = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.rx_done !== 1'b1 && n < 10);
      tests_run++;
      if (bus.rx_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL frame_ack %h: rx_done=%b required 1 within 10 cycles", d, bus.rx_done);
      end
      bus.rx_receive = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({bus.rx_done, bus.cpu_rd_valid, bus.cpu_tx_ready, bus.tx_start,
           bus.overrun, bus.echo_drop} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b required 000000",
                  {bus.rx_done, bus.cpu_rd_valid, bus.cpu_tx_ready, bus.tx_start,
                   bus.overrun, bus.echo_drop});
      end
      tests_run++;
      if ({bus.cpu_rd_data, bus.tx_data, bus.rx_level, bus.overrun_cnt} !== 27'b0) begin
         tests_failed++;
         $display("FAIL reset_values: rd_data=%h tx_data=%h level=%0d cnt=%0d required all 0",
                  bus.cpu_rd_data, bus.tx_data, bus.rx_level, bus.overrun_cnt);
      end
   endtask

   task automatic test_rx_single();
      do_reset();
      bus.rx_data    = 8'hA5;
      bus.rx_receive = 1'b1;
      tests_run++;
      if (bus.rx_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL rx_done_early: got %b required 0", bus.rx_done);
      end
      tick();
      tests_run++;
      if ({bus.rx_done, bus.cpu_rd_valid, bus.cpu_rd_data, bus.rx_level} !== {1'b1, 1'b1, 8'hA5, 3'd1}) begin
         tests_failed++;
         $display("FAIL rx_first: done=%b valid=%b data=%h level=%0d required 1 1 a5 1",
                  bus.rx_done, bus.cpu_rd_valid, bus.cpu_rd_data, bus.rx_level);
      end
      tick();
      tests_run++;
      if (bus.rx_done !== 1'b1 || bus.rx_level !== 3'd1) begin
         tests_failed++;
         $display("FAIL rx_hold: done=%b level=%0d required 1 1", bus.rx_done, bus.rx_level);
      end
      bus.rx_receive = 1'b0;
      tick();
      tests_run++;
      if (bus.rx_done !== 1'b0 || bus.rx_level !== 3'd1 || bus.cpu_rd_data !== 8'hA5) begin
         tests_failed++;
         $display("FAIL rx_release: done=%b level=%0d data=%h required 0 1 a5",
                  bus.rx_done, bus.rx_level, bus.cpu_rd_data);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int i = 1; i <= 5; i++) send_frame(8'(i));
      tests_run++;
      if (bus.rx_level !== 3'd4 || bus.overrun !== 1'b1 || bus.overrun_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL overrun_fill: level=%0d overrun=%b cnt=%0d required 4 1 1",
                  bus.rx_level, bus.overrun, bus.overrun_cnt);
      end
      for (int i = 1; i <= 4; i++) begin
         tests_run++;
         if (bus.cpu_rd_valid !== 1'b1 || bus.cpu_rd_data !== 8'(i)) begin
            tests_failed++;
            $display("FAIL pop_%0d: valid=%b data=%h required 1 %h",
                     i, bus.cpu_rd_valid, bus.cpu_rd_data, 8'(i));
         end
         bus.cpu_rd_ready = 1'b1;
         tick();
         bus.cpu_rd_ready = 1'b0;
      end
      tests_run++;
      if (bus.cpu_rd_valid !== 1'b0 || bus.rx_level !== 3'd0) begin
         tests_failed++;
         $display("FAIL drained: valid=%b level=%0d required 0 0", bus.cpu_rd_valid, bus.rx_level);
      end
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      tests_run++;
      if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL clr_status: overrun=%b cnt=%0d required 0 0", bus.overrun, bus.overrun_cnt);
      end
   endtask

   task automatic test_fifo_boundaries();
      do_reset();
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i));
      // Push while full with a same-cycle pop: still an overrun, pop proceeds.
      bus.rx_data      = 8'h14;
      bus.rx_receive   = 1'b1;
      bus.cpu_rd_ready = 1'b1;
      tick();
      bus.cpu_rd_ready = 1'b0;
      bus.rx_receive   = 1'b0;
      tests_run++;
      if (bus.rx_level !== 3'd3 || bus.overrun_cnt !== 8'd1 || bus.cpu_rd_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL full_push_pop: level=%0d cnt=%0d head=%h required 3 1 11",
                  bus.rx_level, bus.overrun_cnt, bus.cpu_rd_data);
      end
      tick();
      send_frame(8'h15);
      // Clear coinciding with a new overrun: set wins, count restarts at 1.
      bus.rx_data    = 8'h16;
      bus.rx_receive = 1'b1;
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      bus.rx_receive = 1'b0;
      tests_run++;
      if (bus.overrun !== 1'b1 || bus.overrun_cnt !== 8'd1 || bus.rx_level !== 3'd4) begin
         tests_failed++;
         $display("FAIL clr_vs_overrun: overrun=%b cnt=%0d level=%0d required 1 1 4",
                  bus.overrun, bus.overrun_cnt, bus.rx_level);
      end
      tick();
      bus.cpu_rd_ready = 1'b1;
      tick();
      bus.cpu_rd_ready = 1'b0;
      // Simultaneous push and pop with partial occupancy keeps the level.
      bus.rx_data      = 8'h17;
      bus.rx_receive   = 1'b1;
      bus.cpu_rd_ready = 1'b1;
      tick();
      bus.cpu_rd_ready = 1'b0;
      bus.rx_receive   = 1'b0;
      tests_run++;
      if (bus.rx_level !== 3'd3 || bus.cpu_rd_data !== 8'h13 || bus.overrun_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL push_pop_level: level=%0d head=%h cnt=%0d required 3 13 1",
                  bus.rx_level, bus.cpu_rd_data, bus.overrun_cnt);
      end
      tick();
   endtask

   task automatic test_tx_single();
      int n;
      int bad;
      do_reset();
      bus.cpu_tx_data  = 8'h3C;
      bus.cpu_tx_valid = 1'b1;
      tick();
      tests_run++;
      if ({bus.cpu_tx_ready, bus.tx_start, bus.tx_data} !== {1'b1, 1'b1, 8'h3C}) begin
         tests_failed++;
         $display("FAIL tx_grant: ready=%b start=%b data=%h required 1 1 3c",
                  bus.cpu_tx_ready, bus.tx_start, bus.tx_data);
      end
      bus.cpu_tx_valid = 1'b0;
      tick();
      tests_run++;
      if ({bus.cpu_tx_ready, bus.tx_start, bus.tx_busy} !== 3'b011) begin
         tests_failed++;
         $display("FAIL tx_start_hold: ready=%b start=%b busy=%b required 0 1 1",
                  bus.cpu_tx_ready, bus.tx_start, bus.tx_busy);
      end
      tick();
      tests_run++;
      if (bus.tx_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL tx_start_drop: start=%b required 0", bus.tx_start);
      end
      bus.cpu_tx_data  = 8'h99;
      bus.cpu_tx_valid = 1'b1;
      n   = 0;
      bad = 0;
      while (bus.tx_busy === 1'b1 && n < 40) begin
         if (bus.tx_start !== 1'b0 || bus.cpu_tx_ready !== 1'b0 || bus.tx_data !== 8'h3C) bad++;
         tick();
         n++;
      end
      tests_run++;
      if (bad != 0 || bus.tx_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL tx_while_busy: bad_cycles=%0d busy=%b required 0 0", bad, bus.tx_busy);
      end
      tick();
      tests_run++;
      if (bus.tx_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL tx_regrant_gap: start=%b required 0", bus.tx_start);
      end
      n = 0;
      while (bus.tx_start !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      tests_run++;
      if ({bus.tx_start, bus.cpu_tx_ready, bus.tx_data} !== {1'b1, 1'b1, 8'h99}) begin
         tests_failed++;
         $display("FAIL tx_second: start=%b ready=%b data=%h required 1 1 99",
                  bus.tx_start, bus.cpu_tx_ready, bus.tx_data);
      end
      bus.cpu_tx_valid = 1'b0;
      repeat (15) tick();
   endtask

   task automatic test_echo_alternate();
      int n;
      do_reset();
      bus.echo_en      = 1'b1;
      bus.cpu_tx_data  = 8'h77;
      bus.cpu_tx_valid = 1'b1;
      bus.rx_data      = 8'h55;
      bus.rx_receive   = 1'b1;
      tick();
      bus.rx_receive = 1'b0;
      n = 0;
      while (tx_log.size() < 3 && n < 150) begin
         tick();
         n++;
      end
      bus.cpu_tx_valid = 1'b0;
      tests_run++;
      if (tx_log.size() < 3) begin
         tests_failed++;
         $display("FAIL echo_order_count: sent=%0d required >= 3", tx_log.size());
      end else begin
         tests_run++;
         if ({tx_log[0], tx_log[1], tx_log[2]} !== {8'h77, 8'h55, 8'h77}) begin
            tests_failed++;
            $display("FAIL echo_order: got %h %h %h required 77 55 77",
                     tx_log[0], tx_log[1], tx_log[2]);
         end
      end
      repeat (15) tick();
   endtask

   task automatic test_echo_drop();
      int n;
      do_reset();
      bus.echo_en = 1'b1;
      busy_stuck  = 1'b1;
      send_frame(8'h11);
      send_frame(8'h22);
      tests_run++;
      if (bus.echo_drop !== 1'b1 || bus.tx_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL echo_drop: drop=%b start=%b required 1 0", bus.echo_drop, bus.tx_start);
      end
      bus.echo_en = 1'b0;
      busy_stuck  = 1'b0;
      n = 0;
      while (bus.tx_start !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      tests_run++;
      if ({bus.tx_start, bus.cpu_tx_ready, bus.tx_data} !== {1'b1, 1'b0, 8'h11}) begin
         tests_failed++;
         $display("FAIL echo_retained: start=%b ready=%b data=%h required 1 0 11",
                  bus.tx_start, bus.cpu_tx_ready, bus.tx_data);
      end
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      tests_run++;
      if (bus.echo_drop !== 1'b0) begin
         tests_failed++;
         $display("FAIL echo_drop_clr: drop=%b required 0", bus.echo_drop);
      end
      repeat (15) tick();
   endtask

   task automatic test_reset_midstream();
      do_reset();
      model_en         = 1'b0;
      bus.cpu_tx_data  = 8'h5A;
      bus.cpu_tx_valid = 1'b1;
      bus.rx_data      = 8'hC3;
      bus.rx_receive   = 1'b1;
      tick();
      tests_run++;
      if ({bus.tx_start, bus.rx_done, bus.rx_level} !== {1'b1, 1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL mid_setup: start=%b done=%b level=%0d required 1 1 1",
                  bus.tx_start, bus.rx_done, bus.rx_level);
      end
      nreset           = 1'b0;
      bus.cpu_tx_valid = 1'b0;
      bus.rx_receive   = 1'b0;
      tick();
      tests_run++;
      if ({bus.tx_start, bus.rx_done, bus.rx_level, bus.cpu_rd_valid, bus.tx_data} !== 14'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: start=%b done=%b level=%0d valid=%b tx_data=%h required 0 0 0 0 00",
                  bus.tx_start, bus.rx_done, bus.rx_level, bus.cpu_rd_valid, bus.tx_data);
      end
      nreset   = 1'b1;
      model_en = 1'b1;
      tx_log.delete();
      send_frame(8'h3A);
      tests_run++;
      if (bus.rx_level !== 3'd1 || bus.cpu_rd_data !== 8'h3A) begin
         tests_failed++;
         $display("FAIL resume_rx: level=%0d data=%h required 1 3a", bus.rx_level, bus.cpu_rd_data);
      end
      bus.cpu_tx_data  = 8'h6B;
      bus.cpu_tx_valid = 1'b1;
      tick();
      bus.cpu_tx_valid = 1'b0;
      tests_run++;
      if ({bus.tx_start, bus.tx_data} !== {1'b1, 8'h6B}) begin
         tests_failed++;
         $display("FAIL resume_tx: start=%b data=%h required 1 6b", bus.tx_start, bus.tx_data);
      end
      repeat (15) tick();
      tests_run++;
      if (tx_log.size() != 1) begin
         tests_failed++;
         $display("FAIL resume_tx_count: sent=%0d required 1", tx_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_rx_single();
      test_overrun();
      test_fifo_boundaries();
      test_tx_single();
      test_echo_alternate();
      test_echo_drop();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
